// File: rtl/lfsr_frame_rx.sv
// lfsr_frame_rx: receive side of the LFSR stream-cipher link (SOF, key, tap, len, payload).
// Optional macro LFSR_FRAME_CHK_EN adds a trailing plaintext XOR checksum byte per frame.
module lfsr_frame_rx #(
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter bit         ZERO_KEY_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_en,
    input  logic       stop,
    output logic [7:0] out_byte,
    output logic       out_en,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_TAP  = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4
`ifdef LFSR_FRAME_CHK_EN
        , ST_CHK = 3'd5
`endif
    } state_t;

    // Same feedback as the encryptor: shift left, feed back S[7] ^ S[tap].
    function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [2:0] t);
        return {s[6:0], s[7] ^ s[t]};
    endfunction

    state_t     state_r;
    logic [7:0] lfsr_r;
    logic [2:0] tap_r;
    logic [7:0] len_cnt_r;
    logic [7:0] out_byte_r;
    logic       out_en_r;
    logic       busy_r;
    logic       frame_done_r;
    logic       frame_err_r;
    logic [7:0] plain_s;
`ifdef LFSR_FRAME_CHK_EN
    logic [7:0] chk_r;
`endif

    assign plain_s    = in_byte ^ lfsr_r;
    assign out_byte   = out_byte_r;
    assign out_en     = out_en_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;

    // Frame parser FSM with keystream generator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= 8'h00;
            tap_r        <= 3'd0;
            len_cnt_r    <= 8'h00;
            out_byte_r   <= 8'h00;
            out_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef LFSR_FRAME_CHK_EN
            chk_r        <= 8'h00;
`endif
        end else begin
            out_en_r     <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            // stop wins over in_en; the byte in the same cycle is dropped.
            if (state_r != ST_IDLE && stop) begin
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                frame_err_r <= 1'b1;
            end else if (in_en) begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_byte == SOF_BYTE) begin
                            state_r <= ST_KEY;
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_KEY: begin
                        if (ZERO_KEY_ERR && in_byte == 8'h00) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end else begin
                            lfsr_r  <= in_byte;
                            state_r <= ST_TAP;
                        end
                    end
                    ST_TAP: begin
                        if (in_byte[7:3] != 5'd0 || in_byte[2:0] == 3'd7) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end else begin
                            tap_r   <= in_byte[2:0];
                            state_r <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        len_cnt_r <= in_byte;
`ifdef LFSR_FRAME_CHK_EN
                        chk_r     <= 8'h00;
`endif
                        if (in_byte == 8'h00) begin
`ifdef LFSR_FRAME_CHK_EN
                            state_r      <= ST_CHK;
`else
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
`endif
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        out_byte_r <= plain_s;
                        out_en_r   <= 1'b1;
                        lfsr_r     <= lfsr_step(lfsr_r, tap_r);
                        len_cnt_r  <= len_cnt_r - 8'd1;
`ifdef LFSR_FRAME_CHK_EN
                        chk_r      <= chk_r ^ plain_s;
`endif
                        if (len_cnt_r == 8'd1) begin
`ifdef LFSR_FRAME_CHK_EN
                            state_r      <= ST_CHK;
`else
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                            frame_done_r <= 1'b1;
`endif
                        end
                    end
`ifdef LFSR_FRAME_CHK_EN
                    ST_CHK: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (in_byte == chk_r) begin
                            frame_done_r <= 1'b1;
                        end else begin
                            frame_err_r  <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_frame_rx.sv
// tb_lfsr_frame_rx: directed frames checked every cycle against a position-indexed frame model.
// Build with +define+LFSR_FRAME_CHK_EN to exercise the checksum variant.
module tb_lfsr_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_en;
    logic       stop;
    logic [7:0] out_byte;
    logic       out_en;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    lfsr_frame_rx dut (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_en      (in_en),
        .stop       (stop),
        .out_byte   (out_byte),
        .out_en     (out_en),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_done = 0;
    int n_err = 0;
    logic [7:0] out_log[$];
    logic [7:0] plain[0:255];

    // Model state: position within the frame (0 idle, 1 key, 2 tap, 3 len, 4 payload, 5 checksum).
    int         pos = 0;
    logic [7:0] m_key = 8'h00;
    logic [2:0] m_tap = 3'd0;
    int         m_len = 0;
    int         m_idx = 0;
    logic [7:0] m_xsum = 8'h00;
    logic [7:0] e_out_byte = 8'h00;
    logic       e_out_en = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;
    logic       e_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keystream byte n of a frame: key advanced n times.
    function automatic logic [7:0] ks(input logic [7:0] key, input logic [2:0] tap, input int n);
        logic [7:0] s;
        s = key;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[tap]};
        return s;
    endfunction

    function automatic logic [7:0] enc(input logic [7:0] key, input logic [2:0] tap,
                                       input logic [7:0] p, input int n);
        return p ^ ks(key, tap, n);
    endfunction

    task automatic model_reset();
        pos = 0;
        e_out_byte = 8'h00;
        e_out_en = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic end_payload();
`ifdef LFSR_FRAME_CHK_EN
        pos = 5;
`else
        e_done = 1'b1;
        pos = 0;
`endif
    endtask

    task automatic model_step(input logic en, input logic [7:0] b, input logic stp);
        logic [7:0] p;
        e_out_en = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        if (pos != 0 && stp) begin
            e_err = 1'b1;
            pos = 0;
        end else if (en) begin
            case (pos)
                0: if (b == 8'hA5) pos = 1;
                1: if (b == 8'h00) begin e_err = 1'b1; pos = 0; end
                   else begin m_key = b; pos = 2; end
                2: if (b >= 8'd7) begin e_err = 1'b1; pos = 0; end
                   else begin m_tap = b[2:0]; pos = 3; end
                3: begin
                    m_len = int'(b);
                    m_idx = 0;
                    m_xsum = 8'h00;
                    if (m_len == 0) end_payload();
                    else pos = 4;
                end
                4: begin
                    p = b ^ ks(m_key, m_tap, m_idx);
                    e_out_byte = p;
                    e_out_en = 1'b1;
                    m_xsum = m_xsum ^ p;
                    m_idx++;
                    if (m_idx == m_len) end_payload();
                end
                5: begin
                    if (b == m_xsum) e_done = 1'b1;
                    else e_err = 1'b1;
                    pos = 0;
                end
                default: pos = 0;
            endcase
        end
        e_busy = (pos != 0);
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        check("out_en", out_en, e_out_en);
        check("out_byte", out_byte, e_out_byte);
        check("busy", busy, e_busy);
        check("frame_done", frame_done, e_done);
        check("frame_err", frame_err, e_err);
        check("done_err_excl", frame_done & frame_err, 1'b0);
        if (out_en) begin n_strobe++; out_log.push_back(out_byte); end
        if (frame_done) n_done++;
        if (frame_err) n_err++;
    end

    // One clock of stimulus; inputs change 2 time units after the active edge.
    task automatic cycle(input logic en, input logic [7:0] b, input logic stp);
        in_en = en;
        in_byte = b;
        stop = stp;
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(en, b, stp);
        #2;
        in_en = 1'b0;
        stop = 1'b0;
    endtask

    task automatic gap(input int gmax);
        repeat ($urandom_range(0, gmax)) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_counts();
        n_strobe = 0;
        n_done = 0;
        n_err = 0;
        out_log.delete();
    endtask

    // Send a frame of plain[0..len-1]; only nsend payload bytes go out, stop raised on stop_at.
    task automatic send_frame(input logic [7:0] key, input logic [2:0] tap, input int len,
                              input int nsend, input int gmax, input int stop_at);
        logic [7:0] x;
        x = 8'h00;
        cycle(1'b1, 8'hA5, 1'b0); gap(gmax);
        cycle(1'b1, key, 1'b0); gap(gmax);
        cycle(1'b1, {5'd0, tap}, 1'b0); gap(gmax);
        cycle(1'b1, len[7:0], 1'b0); gap(gmax);
        for (int i = 0; i < nsend; i++) begin
            x = x ^ plain[i];
            cycle(1'b1, enc(key, tap, plain[i], i), (i == stop_at));
            if (i == stop_at) return;
            gap(gmax);
        end
`ifdef LFSR_FRAME_CHK_EN
        if (nsend == len) cycle(1'b1, x, 1'b0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        in_en = 1'b0;
        in_byte = 8'h00;
        stop = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) plain[i] = 8'h61 + 8'(i);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_busy", busy, 1'b0);

        // Hand-computed keystream pins for the model.
        check("pin_c0", enc(8'h95, 3'd4, 8'h61, 0), 8'hF4);
        check("pin_c1", enc(8'h95, 3'd4, 8'h62, 1), 8'h48);
        check("pin_c2", enc(8'h95, 3'd4, 8'h63, 2), 8'h37);
        check("pin_k76", enc(8'h76, 3'd6, 8'h62, 1), 8'h8F);

        // Plain frame, then the same frame back-to-back with random gaps.
        clear_counts();
        send_frame(8'h95, 3'd4, 8, 8, 0, -1);
        send_frame(8'h95, 3'd4, 8, 8, 3, -1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t12_strobes", n_strobe, 16);
        check("t12_done", n_done, 2);
        check("t12_last", out_log[15], 8'h68);

        // Junk before SOF, literal ciphertext for key 76 tap 6.
        clear_counts();
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h13, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h76, 1'b0);
        cycle(1'b1, 8'h06, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h17, 1'b0);
        cycle(1'b1, 8'h8F, 1'b0);
`ifdef LFSR_FRAME_CHK_EN
        cycle(1'b1, 8'h03, 1'b0);
`endif
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t3_strobes", n_strobe, 2);
        check("t3_b0", out_log[0], 8'h61);
        check("t3_b1", out_log[1], 8'h62);

        // Header errors, then a good frame.
        clear_counts();
        cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h9E, 1'b0); cycle(1'b1, 8'h07, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h9E, 1'b0); cycle(1'b1, 8'h09, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("t4_err", n_err, 3);
        check("t4_strobes", n_strobe, 0);
        send_frame(8'h95, 3'd4, 8, 8, 0, -1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t4_done", n_done, 1);
        check("t4_strobes2", n_strobe, 8);

        // stop on the 4th payload byte.
        clear_counts();
        send_frame(8'h95, 3'd4, 8, 8, 0, 3);
        check("t5_busy_low", busy, 1'b0);
        check("t5_err_now", frame_err, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t5_strobes", n_strobe, 3);
        check("t5_err", n_err, 1);

        // Asynchronous reset right after a strobe, mid-frame.
        clear_counts();
        send_frame(8'h95, 3'd4, 8, 3, 0, -1);
        check("t5r_pre_en", out_en, 1'b1);
        reset = 1'b0;
        #1;
        check("t5r_out_en", out_en, 1'b0);
        check("t5r_out_byte", out_byte, 8'h00);
        check("t5r_busy", busy, 1'b0);
        model_reset();
        cycle(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        check("t5r_no_pulse", n_done + n_err, 0);
        clear_counts();
        send_frame(8'h95, 3'd4, 8, 8, 1, -1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t5r_after_done", n_done, 1);
        check("t5r_after_last", out_log[7], 8'h68);

`ifdef LFSR_FRAME_CHK_EN
        // Checksum match, mismatch, and empty payload.
        clear_counts();
        cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h95, 1'b0);
        cycle(1'b1, 8'h04, 1'b0); cycle(1'b1, 8'h08, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, enc(8'h95, 3'd4, plain[i], i), 1'b0);
        cycle(1'b1, 8'h09, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t6_bad_err", n_err, 1);
        check("t6_bad_done", n_done, 0);
        clear_counts();
        cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h9E, 1'b0);
        cycle(1'b1, 8'h01, 1'b0); cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        check("t6_empty_done", n_done, 1);
        check("t6_empty_err", n_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
